byte_2_word_n: RTL and testbench
================================

Name: byte_2_word_n

Overview:
Parametrised successor to the two-byte word assembler used behind the UART receiver. It packs BYTES_PER_WORD consecutive received bytes into one word, with selectable byte order per word. The output is a registered word with a valid/ready handshake and overrun detection. It sits between the UART RX byte stream and word-oriented consumers such as the register bank or command decoder.

Parameters:
BYTES_PER_WORD, 2, number of bytes per output word; legal range 2..8.
BYTE_W, 8, width of one input byte in bits.
TIMEOUT_CYC, 1024, number of ce-qualified idle cycles before a partial word is flushed; used only with BYTE_TIMEOUT_EN.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
ce  in  1  clock enable; all state advances only when ce=1.
sync_clr  in  1  synchronous clear of the partial word and byte counter; does not affect the output register.
byte_dv  in  1  input byte valid, single-cycle strobe qualified by ce.
byte_in  in  BYTE_W  input byte.
msb_first  in  1  byte order: 1 = first byte lands in the most-significant byte; 0 = first byte lands in the least-significant byte.
word_rdy  in  1  downstream ready.
word_dv  out  1  output word valid; held until accepted.
word  out  BYTES_PER_WORD*BYTE_W  assembled word, registered.
byte_idx  out  clog2(BYTES_PER_WORD)  number of bytes collected in the current partial word.
overrun  out  1  sticky; a completed word was dropped.
timeout  out  1  one-cycle pulse when a partial word is flushed; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values: word_dv=0, word=0, byte_idx=0, overrun=0, timeout=0, collector=0, latched order=0.
- Every register update below requires ce=1. With ce=0 all state holds.
- Collecting:
  - On byte_dv, byte_in is written into collector slot byte_idx, and byte_idx increments.
  - msb_first is latched when byte_idx=0 and byte_dv=1. The latched value governs the whole word, so toggling msb_first mid-word has no effect until the next word.
  - Slot mapping: slot k goes to bits [(k+1)*BYTE_W-1 : k*BYTE_W] when the latched order is 0, and to slot BYTES_PER_WORD-1-k when it is 1.
- Completion: a byte_dv with byte_idx=BYTES_PER_WORD-1 completes the word.
  - byte_idx wraps to 0.
  - The assembled value, including the current byte, is loaded into word.
  - word_dv=1 on the next cycle, giving 1-cycle latency from the last byte_dv.
- Handshake:
  - A word is accepted when word_dv=1 and word_rdy=1 with ce=1.
  - word_dv then clears next cycle unless a new completion happens in the same cycle. In that case the new word loads and word_dv stays 1, with no bubble and no overrun.
  - word is stable while word_dv=1 and not accepted.
- Overrun: if a completion occurs while word_dv=1 and word_rdy=0:
  - the new word is discarded;
  - word is unchanged;
  - overrun is set and stays set until rst or sync_clr;
  - byte_idx still wraps to 0.
- sync_clr: clears byte_idx, the collector and overrun. The output register and word_dv are untouched, so a pending word is still delivered. If sync_clr and byte_dv occur in the same cycle, sync_clr wins and the byte is dropped.
- Reset mid-word: the partial word is discarded, and the next byte starts at slot 0.
- word_rdy is ignored while word_dv=0.

Optional Feature:
BYTE_TIMEOUT_EN:
- Defined: a counter increments on each ce cycle where byte_idx!=0 and byte_dv=0. It resets on any byte_dv, or whenever byte_idx=0.
  - When it reaches TIMEOUT_CYC, byte_idx and the collector clear and timeout pulses high for 1 cycle.
  - No word is emitted and overrun is unaffected.
- Undefined: no counter exists, a partial word waits indefinitely, and timeout is constant 0.

Test Plan:
- BYTES_PER_WORD=2, msb_first=0, word_rdy=1; bytes 0x34 then 0x12 -> word=0x1234 with word_dv=1 one cycle after the second byte; word_dv low the following cycle.
- BYTES_PER_WORD=4, msb_first=1; bytes 0xDE,0xAD,0xBE,0xEF -> word=0xDEADBEEF. Toggle msb_first after the 2nd byte -> result unchanged.
- word_rdy=0, two full words 0x1111 then 0x2222 -> word stays 0x1111, overrun=1; raise word_rdy -> 0x1111 accepted, word_dv=0, overrun remains 1 until sync_clr.
- Back-to-back: with word_rdy=1, last byte of word B arrives in the same cycle word A is accepted -> word_dv stays 1, word=B, overrun=0.
- ce=0 for 5 cycles between bytes, with byte_dv pulses present during ce=0 -> those bytes are ignored and byte_idx is unchanged; assert rst after 1 byte -> all outputs 0, and the next 2 bytes form a fresh word.
- With BYTE_TIMEOUT_EN and TIMEOUT_CYC=16: one byte, then 16 idle cycles -> timeout pulse, byte_idx=0; bytes 0xAA,0xBB -> word=0xBBAA (msb_first=0).

Source files
------------

// File: rtl/byte_2_word_n.sv
// ============================================================================
// Module      : byte_2_word_n
// Description : Packs BYTES_PER_WORD bytes into a registered word with a
//               per-word byte order, a valid/ready handshake and a sticky
//               overrun flag. Partial-word flush is enabled by BYTE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_2_word_n #(
  parameter int BYTES_PER_WORD = 2,
  parameter int BYTE_W         = 8,
  parameter int TIMEOUT_CYC    = 1024,
  parameter int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ce,
  input  logic                             sync_clr,
  input  logic                             byte_dv,
  input  logic [BYTE_W-1:0]                byte_in,
  input  logic                             msb_first,
  input  logic                             word_rdy,
  output logic                             word_dv,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] word,
  output logic [IDX_W-1:0]                 byte_idx,
  output logic                             overrun,
  output logic                             timeout
);

  localparam int          c_word_w = BYTES_PER_WORD * BYTE_W;
  localparam [IDX_W-1:0]  c_last   = IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_W-1:0]   r_coll [BYTES_PER_WORD];
  logic [IDX_W-1:0]    r_idx;
  logic                r_order;
  logic                r_word_dv;
  logic [c_word_w-1:0] r_word;
  logic                r_overrun;

  logic [BYTE_W-1:0]   w_slot [BYTES_PER_WORD];
  logic [c_word_w-1:0] w_asm;
  logic                w_order;
  logic                w_take;
  logic                w_complete;
  logic                w_accept;
  logic                w_load;
  logic                w_drop;
  logic                w_to_hit;

  // A byte is only taken when sync_clr is low; sync_clr always wins.
  assign w_take     = ce & byte_dv & ~sync_clr;
  assign w_complete = w_take & (r_idx == c_last);
  assign w_accept   = ce & r_word_dv & word_rdy;
  assign w_load     = w_complete & (~r_word_dv | word_rdy);
  assign w_drop     = w_complete & r_word_dv & ~word_rdy;

  // The first byte of a word takes its order from the live input.
  assign w_order = (r_idx == '0) ? msb_first : r_order;

  generate
    for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_slot
      assign w_slot[k] = (r_idx == IDX_W'(k)) ? byte_in : r_coll[k];
    end
  endgenerate

  always_comb begin
    w_asm = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (w_order)
        w_asm[(BYTES_PER_WORD-1-k)*BYTE_W +: BYTE_W] = w_slot[k];
      else
        w_asm[k*BYTE_W +: BYTE_W] = w_slot[k];
    end
  end

  // Collector, byte counter and latched order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_order <= 1'b0;
      for (int k = 0; k < BYTES_PER_WORD; k++) r_coll[k] <= '0;
    end else if (ce) begin
      if (sync_clr || w_to_hit) begin
        r_idx <= '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) r_coll[k] <= '0;
      end else if (byte_dv) begin
        if (r_idx == '0) r_order <= msb_first;
        if (r_idx == c_last) begin
          r_idx <= '0;
          for (int k = 0; k < BYTES_PER_WORD; k++) r_coll[k] <= '0;
        end else begin
          r_coll[r_idx] <= byte_in;
          r_idx         <= r_idx + 1'b1;
        end
      end
    end
  end

  // Output register: a completion coinciding with acceptance reloads without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_dv <= 1'b0;
      r_word    <= '0;
    end else if (w_load) begin
      r_word_dv <= 1'b1;
      r_word    <= w_asm;
    end else if (w_accept) begin
      r_word_dv <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_overrun <= 1'b0;
    else if (ce && sync_clr)
      r_overrun <= 1'b0;
    else if (w_drop)
      r_overrun <= 1'b1;
  end

`ifdef BYTE_TIMEOUT_EN
  localparam int          c_to_w  = $clog2(TIMEOUT_CYC + 1);
  localparam [c_to_w-1:0] c_to_hi = c_to_w'(TIMEOUT_CYC - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_timeout;

  // Flush fires on the idle cycle that brings the count to TIMEOUT_CYC.
  assign w_to_hit = ce & ~sync_clr & ~byte_dv & (r_idx != '0) & (r_to_cnt == c_to_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (ce) begin
      r_timeout <= w_to_hit;
      if (byte_dv || sync_clr || w_to_hit || (r_idx == '0))
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign word_dv  = r_word_dv;
  assign word     = r_word;
  assign byte_idx = r_idx;
  assign overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_byte_2_word_n.sv
// ============================================================================
// Module      : tb_byte_2_word_n
// Description : Directed self-checking bench for byte_2_word_n with 2- and
//               4-byte instances; timeout case selected by BYTE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_2_word_n;

  logic        clk = 1'b0;
  logic        rst, ce, sync_clr, msb_first, word_rdy;
  logic [7:0]  byte_in;
  logic        dv2, dv4;

  logic        wdv2, ovr2, to2;
  logic [15:0] word2;
  logic [0:0]  idx2;
  logic        wdv4, ovr4, to4;
  logic [31:0] word4;
  logic [1:0]  idx4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  byte_2_word_n #(.BYTES_PER_WORD(2), .BYTE_W(8), .TIMEOUT_CYC(16)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .sync_clr(sync_clr), .byte_dv(dv2),
    .byte_in(byte_in), .msb_first(msb_first), .word_rdy(word_rdy),
    .word_dv(wdv2), .word(word2), .byte_idx(idx2), .overrun(ovr2), .timeout(to2)
  );

  byte_2_word_n #(.BYTES_PER_WORD(4), .BYTE_W(8), .TIMEOUT_CYC(16)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .sync_clr(sync_clr), .byte_dv(dv4),
    .byte_in(byte_in), .msb_first(msb_first), .word_rdy(word_rdy),
    .word_dv(wdv4), .word(word4), .byte_idx(idx4), .overrun(ovr4), .timeout(to4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({wdv2, word2, idx2, ovr2, to2} !== 20'h0) begin
      n_fail++; $display("FAIL reset_dut2 got %h expected 0", {wdv2, word2, idx2, ovr2, to2});
    end
    n_tests++;
    if ({wdv4, word4, idx4, ovr4, to4} !== 37'h0) begin
      n_fail++; $display("FAIL reset_dut4 got %h expected 0", {wdv4, word4, idx4, ovr4, to4});
    end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_basic2();
    msb_first = 1'b0; word_rdy = 1'b1;
    dv2 = 1'b1; byte_in = 8'h34; step();
    n_tests++;
    if (idx2 !== 1'b1) begin n_fail++; $display("FAIL basic_idx got %h expected 1", idx2); end
    byte_in = 8'h12; step();
    dv2 = 1'b0;
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'h1234 || idx2 !== 1'b0) begin
      n_fail++; $display("FAIL basic_word dv=%b word=%h idx=%h expected dv=1 word=1234 idx=0", wdv2, word2, idx2);
    end
    step();
    n_tests++;
    if (wdv2 !== 1'b0) begin n_fail++; $display("FAIL basic_dv_clear got %b expected 0", wdv2); end
  endtask

  task automatic test_order4();
    word_rdy = 1'b1; msb_first = 1'b1;
    dv4 = 1'b1;
    byte_in = 8'hDE; step();
    byte_in = 8'hAD; step();
    n_tests++;
    if (idx4 !== 2'd2) begin n_fail++; $display("FAIL order4_idx got %0d expected 2", idx4); end
    msb_first = 1'b0;
    byte_in = 8'hBE; step();
    byte_in = 8'hEF; step();
    dv4 = 1'b0;
    n_tests++;
    if (wdv4 !== 1'b1 || word4 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL order4_msb dv=%b word=%h expected dv=1 word=deadbeef", wdv4, word4);
    end
    step();
    dv4 = 1'b1;
    byte_in = 8'h01; step();
    byte_in = 8'h02; step();
    msb_first = 1'b1;
    byte_in = 8'h03; step();
    byte_in = 8'h04; step();
    dv4 = 1'b0; msb_first = 1'b0;
    n_tests++;
    if (wdv4 !== 1'b1 || word4 !== 32'h04030201) begin
      n_fail++; $display("FAIL order4_lsb dv=%b word=%h expected dv=1 word=04030201", wdv4, word4);
    end
    step();
  endtask

  task automatic test_overrun();
    msb_first = 1'b0; word_rdy = 1'b0;
    dv2 = 1'b1;
    byte_in = 8'h11; step(); step();
    byte_in = 8'h22; step(); step();
    dv2 = 1'b0;
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'h1111 || ovr2 !== 1'b1 || idx2 !== 1'b0) begin
      n_fail++; $display("FAIL overrun_set dv=%b word=%h ovr=%b idx=%h expected 1 1111 1 0", wdv2, word2, ovr2, idx2);
    end
    word_rdy = 1'b1; step();
    n_tests++;
    if (wdv2 !== 1'b0 || ovr2 !== 1'b1 || word2 !== 16'h1111) begin
      n_fail++; $display("FAIL overrun_accept dv=%b ovr=%b word=%h expected 0 1 1111", wdv2, ovr2, word2);
    end
    step();
    // sync_clr alongside a byte: the byte is dropped
    sync_clr = 1'b1; dv2 = 1'b1; byte_in = 8'h33; step();
    sync_clr = 1'b0; dv2 = 1'b0;
    n_tests++;
    if (ovr2 !== 1'b0 || idx2 !== 1'b0) begin
      n_fail++; $display("FAIL sync_clr ovr=%b idx=%h expected 0 0", ovr2, idx2);
    end
    word_rdy = 1'b0; dv2 = 1'b1;
    byte_in = 8'h44; step();
    byte_in = 8'h55; step();
    byte_in = 8'h66; step();
    dv2 = 1'b0; sync_clr = 1'b1; step();
    sync_clr = 1'b0;
    n_tests++;
    if (idx2 !== 1'b0 || wdv2 !== 1'b1 || word2 !== 16'h5544) begin
      n_fail++; $display("FAIL sync_clr_pending idx=%h dv=%b word=%h expected 0 1 5544", idx2, wdv2, word2);
    end
    word_rdy = 1'b1; step();
    n_tests++;
    if (wdv2 !== 1'b0) begin n_fail++; $display("FAIL sync_clr_deliver dv=%b expected 0", wdv2); end
  endtask

  task automatic test_back_to_back();
    word_rdy = 1'b0; msb_first = 1'b0; dv2 = 1'b1;
    byte_in = 8'hA1; step();
    byte_in = 8'hA2; step();
    byte_in = 8'hB1; step();
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'hA2A1 || idx2 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first dv=%b word=%h idx=%h expected 1 a2a1 1", wdv2, word2, idx2);
    end
    word_rdy = 1'b1; byte_in = 8'hB2; step();
    dv2 = 1'b0;
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'hB2B1 || ovr2 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second dv=%b word=%h ovr=%b expected 1 b2b1 0", wdv2, word2, ovr2);
    end
    step();
    n_tests++;
    if (wdv2 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain dv=%b expected 0", wdv2); end
  endtask

  task automatic test_ce_rst();
    word_rdy = 1'b1; msb_first = 1'b0;
    dv2 = 1'b1; byte_in = 8'h55; step();
    ce = 1'b0; byte_in = 8'h99;
    repeat (5) step();
    n_tests++;
    if (idx2 !== 1'b1 || wdv2 !== 1'b0) begin
      n_fail++; $display("FAIL ce_hold idx=%h dv=%b expected 1 0", idx2, wdv2);
    end
    ce = 1'b1; byte_in = 8'h66; step();
    dv2 = 1'b0;
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'h6655) begin
      n_fail++; $display("FAIL ce_word dv=%b word=%h expected 1 6655", wdv2, word2);
    end
    step();
    dv2 = 1'b1; byte_in = 8'h77; step();
    dv2 = 1'b0;
    rst = 1'b1; #1;
    n_tests++;
    if ({wdv2, word2, idx2, ovr2, to2} !== 20'h0) begin
      n_fail++; $display("FAIL rst_mid got %h expected 0", {wdv2, word2, idx2, ovr2, to2});
    end
    step();
    rst = 1'b0;
    dv2 = 1'b1;
    byte_in = 8'h88; step();
    byte_in = 8'h99; step();
    dv2 = 1'b0;
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'h9988) begin
      n_fail++; $display("FAIL rst_fresh dv=%b word=%h expected 1 9988", wdv2, word2);
    end
    step();
  endtask

`ifdef BYTE_TIMEOUT_EN
  task automatic test_timeout();
    word_rdy = 1'b1; msb_first = 1'b0;
    dv2 = 1'b1; byte_in = 8'h01; step();
    dv2 = 1'b0;
    repeat (15) step();
    n_tests++;
    if (idx2 !== 1'b1 || to2 !== 1'b0) begin
      n_fail++; $display("FAIL to_early idx=%h to=%b expected 1 0", idx2, to2);
    end
    step();
    n_tests++;
    if (idx2 !== 1'b0 || to2 !== 1'b1 || wdv2 !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse idx=%h to=%b dv=%b expected 0 1 0", idx2, to2, wdv2);
    end
    step();
    n_tests++;
    if (to2 !== 1'b0) begin n_fail++; $display("FAIL to_single to=%b expected 0", to2); end
    dv2 = 1'b1;
    byte_in = 8'hAA; step();
    byte_in = 8'hBB; step();
    dv2 = 1'b0;
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'hBBAA) begin
      n_fail++; $display("FAIL to_next dv=%b word=%h expected 1 bbaa", wdv2, word2);
    end
    step();
  endtask
`else
  task automatic test_timeout();
    word_rdy = 1'b1; msb_first = 1'b0;
    dv2 = 1'b1; byte_in = 8'h01; step();
    dv2 = 1'b0;
    repeat (20) step();
    n_tests++;
    if (idx2 !== 1'b1 || to2 !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout idx=%h to=%b expected 1 0", idx2, to2);
    end
    dv2 = 1'b1; byte_in = 8'h02; step();
    dv2 = 1'b0;
    n_tests++;
    if (wdv2 !== 1'b1 || word2 !== 16'h0201) begin
      n_fail++; $display("FAIL no_timeout_word dv=%b word=%h expected 1 0201", wdv2, word2);
    end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; ce = 1'b1; sync_clr = 1'b0; msb_first = 1'b0; word_rdy = 1'b0;
    byte_in = 8'h00; dv2 = 1'b0; dv4 = 1'b0;
    test_reset();
    test_basic2();
    test_order4();
    test_overrun();
    test_back_to_back();
    test_ce_rst();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
